// File: rtl/frame_writeback_ctrl.sv
// Frame write-back controller: walks the display window, presents the pixel index to the
// processing stage and writes its registered result into the result-frame BRAM, one frame per start.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for start
// ARM    | start accepted; waiting for h_loc==0 && v_loc==0 (frame boundary)
// RUN    | counting in-window pixels, one write per pixel, one cycle late
// FLUSH  | write for the last pixel (N-1) is on the BRAM port
// DONE   | done pulse, then back to IDLE
module frame_writeback_ctrl #(
    parameter int H_START = 200,
    parameter int V_START = 150,
    parameter int IMG_W   = 400,
    parameter int IMG_H   = 300,
    parameter int ADDR_W  = 18,
    parameter int PIX_W   = 4
) (
    input  logic                 clk_40,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [10:0]          h_loc,
    input  logic [9:0]           v_loc,
    input  logic [PIX_W-1:0]     pix_r,
    input  logic [PIX_W-1:0]     pix_g,
    input  logic [PIX_W-1:0]     pix_b,
    output logic [ADDR_W-1:0]    wr_add,
    output logic                 bram_we,
    output logic [ADDR_W-1:0]    bram_addr,
    output logic [3*PIX_W-1:0]   bram_din,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [10:0]       H_LO = 11'(H_START);
    localparam logic [10:0]       H_HI = 11'(H_START + IMG_W);
    localparam logic [9:0]        V_LO = 10'(V_START);
    localparam logic [9:0]        V_HI = 10'(V_START + IMG_H);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_W * IMG_H - 1);

    state_t              state;
    state_t              state_nx;
    logic [ADDR_W-1:0]   wr_add_nx;
    logic [ADDR_W-1:0]   bram_addr_nx;
    logic                bram_we_nx;
    logic                in_win;

    assign in_win = (h_loc > H_LO) && (h_loc <= H_HI) && (v_loc > V_LO) && (v_loc <= V_HI);

    always_comb begin
        state_nx     = state;
        wr_add_nx    = wr_add;
        bram_we_nx   = 1'b0;
        bram_addr_nx = bram_addr;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx  = S_ARM;
                    wr_add_nx = '0;
                end
            end
            S_ARM: begin
                if ((h_loc == '0) && (v_loc == '0)) state_nx = S_RUN;
            end
            S_RUN: begin
                if (in_win) begin
                    bram_we_nx   = 1'b1;
                    bram_addr_nx = wr_add;
                    if (wr_add == LAST) state_nx  = S_FLUSH;
                    else                wr_add_nx = wr_add + ADDR_W'(1);
                end
            end
            S_FLUSH: state_nx = S_DONE;
            S_DONE: begin
                state_nx  = S_IDLE;
                wr_add_nx = '0;
            end
            default: begin
                state_nx  = S_IDLE;
                wr_add_nx = '0;
            end
        endcase
        // abort beats everything, including a start seen in the same cycle
        if (abort) begin
            state_nx   = S_IDLE;
            wr_add_nx  = '0;
            bram_we_nx = 1'b0;
        end
    end

    always_ff @(posedge clk_40 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wr_add    <= '0;
            bram_we   <= 1'b0;
            bram_addr <= '0;
        end else begin
            state     <= state_nx;
            wr_add    <= wr_add_nx;
            bram_we   <= bram_we_nx;
            bram_addr <= bram_addr_nx;
        end
    end

    // The pixel for bram_addr arrives from the processing stage's output register in the
    // same cycle as the registered strobe, so the data path is a gated pass-through.
    assign bram_din = bram_we ? {pix_r, pix_g, pix_b} : '0;

    assign busy = (state == S_ARM) || (state == S_RUN) || (state == S_FLUSH);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_frame_writeback_ctrl.sv
// Self-checking bench for frame_writeback_ctrl on a shrunken window/raster; expected writes are
// scheduled arithmetically from the raster position of each in-window pixel.
module tb_frame_writeback_ctrl;

    localparam int H_START = 4;
    localparam int V_START = 3;
    localparam int IMG_W   = 8;
    localparam int IMG_H   = 6;
    localparam int ADDR_W  = 18;
    localparam int PIX_W   = 4;
    localparam int N       = IMG_W * IMG_H;
    localparam int H_TOT   = 16;
    localparam int V_TOT   = 12;
    localparam int FRAME   = H_TOT * V_TOT;

    logic                clk_40 = 1'b0;
    logic                rst_n  = 1'b0;
    logic                start  = 1'b0;
    logic                abort  = 1'b0;
    logic [10:0]         h_loc  = '0;
    logic [9:0]          v_loc  = '0;
    logic [PIX_W-1:0]    pix_r  = '0;
    logic [PIX_W-1:0]    pix_g  = '0;
    logic [PIX_W-1:0]    pix_b  = '0;
    logic [ADDR_W-1:0]   wr_add;
    logic                bram_we;
    logic [ADDR_W-1:0]   bram_addr;
    logic [3*PIX_W-1:0]  bram_din;
    logic                busy;
    logic                done;

    frame_writeback_ctrl #(
        .H_START(H_START), .V_START(V_START), .IMG_W(IMG_W), .IMG_H(IMG_H),
        .ADDR_W(ADDR_W), .PIX_W(PIX_W)
    ) dut (
        .clk_40(clk_40), .rst_n(rst_n), .start(start), .abort(abort),
        .h_loc(h_loc), .v_loc(v_loc), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .wr_add(wr_add), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
        .busy(busy), .done(done)
    );

    always #5 clk_40 = ~clk_40;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         pos = 0;
    bit         chk_en = 1'b1;
    bit         rnd_pix = 1'b0;
    bit         manual_hv = 1'b0;
    bit         run_valid = 1'b0;
    bit         aborted = 1'b0;
    int         s_pos = 0;
    int         a_pos = 0;
    int         last_pos = 0;
    int         pk[N];
    int         prev_wr = 0;
    logic [11:0] drv_pix = '0;
    int         n_wr = 0;
    int         n_done = 0;

    typedef struct {
        logic [10:0] h;
        logic [9:0]  v;
        bit          we;
    } vec_t;
    vec_t tbl[14];

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, pos, act, exp);
        end
    endtask

    // Raster position of every pixel of a frame started at cycle s.
    task automatic plan_run(input int s);
        int b;
        run_valid = 1'b1;
        aborted   = 1'b0;
        s_pos     = s;
        b         = ((s / FRAME) + 1) * FRAME;
        for (int k = 0; k < N; k++)
            pk[k] = b + (V_START + 1 + k / IMG_W) * H_TOT + H_START + 1 + k % IMG_W;
        last_pos = pk[N-1];
    endtask

    task automatic tick();
        int e_we, e_addr, e_busy, e_done, e_wr, cnt;
        bit idle_now;
        idle_now = !run_valid || (aborted ? (pos > a_pos) : (pos > last_pos + 2));
        if (rst_n && start && !abort && idle_now)
            plan_run(pos);
        else if (rst_n && abort && run_valid && !aborted && pos > s_pos && pos <= last_pos + 1) begin
            aborted = 1'b1;
            a_pos   = pos;
        end
        @(posedge clk_40);
        #1;
        pos++;
        start = 1'b0;
        abort = 1'b0;
        if (!manual_hv) begin
            h_loc = 11'(pos % H_TOT);
            v_loc = 10'((pos / H_TOT) % V_TOT);
        end
        drv_pix = rnd_pix ? 12'($urandom) : 12'(prev_wr);
        {pix_r, pix_g, pix_b} = drv_pix;
        e_we = 0; e_addr = 0; e_busy = 0; e_done = 0; e_wr = 0;
        if (run_valid && pos > s_pos && pos <= (aborted ? a_pos : last_pos + 2)) begin
            cnt = 0;
            for (int k = 0; k < N; k++) begin
                if (pk[k] < pos) cnt++;
                if (pk[k] == pos - 1) begin
                    e_we   = 1;
                    e_addr = k;
                end
            end
            if (pos <= last_pos + 1) begin
                e_busy = 1;
                e_wr   = (cnt > N - 1) ? N - 1 : cnt;
            end else begin
                e_done = 1;
                e_wr   = N - 1;
            end
        end
        prev_wr = e_wr;
        #1;
        if (bram_we) n_wr++;
        if (done) n_done++;
        if (chk_en) begin
            cmp("bram_we", int'(bram_we), e_we);
            cmp("busy", int'(busy), e_busy);
            cmp("done", int'(done), e_done);
            cmp("wr_add", int'(wr_add), e_wr);
            if (e_we != 0) begin
                cmp("bram_addr", int'(bram_addr), e_addr);
                cmp("bram_din", int'(bram_din), int'(drv_pix));
            end else begin
                cmp("bram_din_idle", int'(bram_din), 0);
            end
        end
    endtask

    task automatic run_to_end();
        for (int i = 0; i < 6 * FRAME && pos <= last_pos + 3; i++) tick();
    endtask

    task automatic wait_wr(input int target, input string name);
        for (int i = 0; i < 3 * FRAME && prev_wr != target; i++) tick();
        if (prev_wr != target) cmp(name, int'(wr_add), target);
    endtask

    initial begin
        int idx, ab;
        tbl[0]  = '{11'd4,    10'd4,    1'b0};
        tbl[1]  = '{11'd13,   10'd4,    1'b0};
        tbl[2]  = '{11'd5,    10'd3,    1'b0};
        tbl[3]  = '{11'd5,    10'd10,   1'b0};
        tbl[4]  = '{11'd5,    10'd4,    1'b1};
        tbl[5]  = '{11'd12,   10'd4,    1'b1};
        tbl[6]  = '{11'd5,    10'd9,    1'b1};
        tbl[7]  = '{11'd12,   10'd9,    1'b1};
        tbl[8]  = '{11'd13,   10'd9,    1'b0};
        tbl[9]  = '{11'd4,    10'd9,    1'b0};
        tbl[10] = '{11'd0,    10'd0,    1'b0};
        tbl[11] = '{11'd8,    10'd6,    1'b1};
        tbl[12] = '{11'd2047, 10'd1023, 1'b0};
        tbl[13] = '{11'd12,   10'd10,   1'b0};

        // reset, then a frame with no start
        rst_n = 1'b0;
        repeat (3) tick();
        cmp("reset_bram_addr", int'(bram_addr), 0);
        rst_n = 1'b1;
        n_wr = 0;
        repeat (FRAME + 5) tick();
        cmp("idle_writes", n_wr, 0);

        // full frame, start at an arbitrary raster position
        n_wr = 0; n_done = 0;
        start = 1'b1;
        tick();
        run_to_end();
        cmp("full_writes", n_wr, N);
        cmp("full_done_pulses", n_done, 1);

        // start in the middle of the window
        for (int i = 0; i < FRAME + 1 && (pos % FRAME) != 5 * H_TOT + 8; i++) tick();
        n_wr = 0; n_done = 0;
        start = 1'b1;
        tick();
        run_to_end();
        cmp("mid_writes", n_wr, N);
        cmp("mid_done_pulses", n_done, 1);

        // abort part way, then a clean frame
        n_wr = 0; n_done = 0;
        start = 1'b1;
        tick();
        wait_wr(20, "abort_reach");
        abort = 1'b1;
        tick();
        repeat (FRAME) tick();
        cmp("abort_writes", n_wr, 20);
        cmp("abort_done_pulses", n_done, 0);
        n_wr = 0; n_done = 0;
        start = 1'b1;
        tick();
        run_to_end();
        cmp("after_abort_writes", n_wr, N);

        // window boundaries, driven point by point while in RUN
        chk_en = 1'b0;
        manual_hv = 1'b1;
        h_loc = 11'd1; v_loc = 10'd1;
        start = 1'b1;
        tick();
        h_loc = '0; v_loc = '0;
        tick();
        idx = 0;
        for (int i = 0; i < 14; i++) begin
            h_loc = tbl[i].h;
            v_loc = tbl[i].v;
            tick();
            cmp("tbl_we", int'(bram_we), int'(tbl[i].we));
            if (tbl[i].we) cmp("tbl_addr", int'(bram_addr), idx);
            if (tbl[i].we) idx++;
            cmp("tbl_wr_add", int'(wr_add), idx);
        end
        abort = 1'b1;
        tick();
        cmp("tbl_abort_busy", int'(busy), 0);
        manual_hv = 1'b0;
        run_valid = 1'b0;
        tick();
        chk_en = 1'b1;

        // asynchronous reset in the middle of a frame
        start = 1'b1;
        tick();
        wait_wr(N / 2, "rst_reach");
        #2;
        rst_n = 1'b0;
        #1;
        cmp("arst_wr_add", int'(wr_add), 0);
        cmp("arst_bram_we", int'(bram_we), 0);
        cmp("arst_bram_addr", int'(bram_addr), 0);
        cmp("arst_bram_din", int'(bram_din), 0);
        cmp("arst_busy", int'(busy), 0);
        cmp("arst_done", int'(done), 0);
        run_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b1;
        tick();
        rst_n = 1'b1;
        n_wr = 0;
        repeat (FRAME + 5) tick();
        cmp("post_rst_writes", n_wr, 0);

        // randomized frames: random pixels, start times, stray starts and aborts
        rnd_pix = 1'b1;
        for (int it = 0; it < 6; it++) begin
            repeat ($urandom_range(0, FRAME)) tick();
            n_wr = 0;
            start = 1'b1;
            tick();
            if ($urandom_range(0, 1) == 1) begin
                ab = $urandom_range(1, last_pos + 1 - s_pos);
                while (pos < s_pos + ab) tick();
                abort = 1'b1;
                tick();
                repeat (5) tick();
            end else begin
                for (int i = 0; i < 6 * FRAME && pos <= last_pos + 2; i++) begin
                    start = ($urandom_range(0, 15) == 0);
                    tick();
                end
                repeat (3) tick();
                cmp("rnd_writes", n_wr, N);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", pos);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/frame_writeback_ctrl.md
Name: frame_writeback_ctrl

Overview:
- Downstream stage of the pixel-processing (brightness/invert/blur) stage.
- Generates the in-window pixel address `wr_add` that the processing stage uses to derive its read address.
- Captures the processing stage's registered 4-bit R/G/B output and writes it, address-aligned, into the 400x300 result frame BRAM (120000 x 12 bit).
- Runs exactly one full frame per `start` request and reports `busy` and `done`.

Parameters:
- H_START, 200, window opens after this h_loc (first pixel at h_loc = H_START+1)
- V_START, 150, window opens after this v_loc (first line at v_loc = V_START+1)
- IMG_W, 400, pixels per line inside the window
- IMG_H, 300, lines inside the window
- ADDR_W, 18, BRAM address width; IMG_W*IMG_H must not exceed 2^ADDR_W
- PIX_W, 4, bits per colour channel

Ports:
- clk_40 in 1: 40 MHz pixel clock; the only clock
- rst_n in 1: asynchronous, active-low reset
- start in 1: one-cycle request to process one frame; ignored unless state is IDLE
- abort in 1: synchronous cancel; wins over every other event except rst_n
- h_loc in 11: VGA horizontal counter
- v_loc in 10: VGA vertical counter
- pix_r, pix_g, pix_b in PIX_W each: processed pixel, registered one cycle after its wr_add was presented
- wr_add out ADDR_W: current in-window pixel index, fed to the processing stage
- bram_we out 1: write enable of the result BRAM
- bram_addr out ADDR_W: write address
- bram_din out 3*PIX_W: {pix_r, pix_g, pix_b}
- busy out 1: high in ARM, RUN and FLUSH
- done out 1: one-cycle pulse when the frame has been completely written

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; wr_add, bram_addr and bram_din = 0; bram_we, busy and done = 0.
- in_win = (h_loc > H_START) && (h_loc <= H_START+IMG_W) && (v_loc > V_START) && (v_loc <= V_START+IMG_H). Compare combinationally at full h/v width.
- N = IMG_W*IMG_H (120000). wr_add holds values 0..N-1 only.
- IDLE:
  - start=1 -> ARM, busy=1, wr_add=0.
- ARM:
  - Waits for a frame boundary so capture never begins mid-frame.
  - h_loc==0 && v_loc==0 -> RUN.
- RUN:
  - Each cycle with in_win=1: present wr_add. On the next edge, bram_we=1, bram_addr=previous wr_add, bram_din={pix_r,pix_g,pix_b}. This gives a fixed 1-cycle latency matching the processing stage's output register.
  - wr_add increments by 1 per in_win cycle.
  - Cycles with in_win=0: bram_we=0 on the next edge; wr_add holds.
  - In-window cycle with wr_add==N-1 -> FLUSH. wr_add holds at N-1 (no wrap to 0).
- FLUSH (one cycle):
  - Issues the write for address N-1 (bram_we=1).
  - -> DONE.
- DONE (one cycle):
  - done=1, busy=0, bram_we=0.
  - -> IDLE. wr_add returns to 0.
- bram_we is never asserted in IDLE, ARM or DONE.
- Exactly N writes per frame, addresses 0..N-1, strictly ascending, each written once.
- Simultaneous start and abort in IDLE: abort wins; stay IDLE.
- abort in ARM, RUN or FLUSH -> IDLE next edge:
  - bram_we forced 0 that edge; a pending FLUSH write is discarded.
  - done is not pulsed; wr_add=0.
- start while busy or in DONE: ignored; no queueing.
- rst_n asserted mid-frame: immediate IDLE with all outputs at reset values. After release, a new start is required.
- No gap in the VGA counters inside a frame is assumed. If v_loc wraps to 0 during RUN before N pixels are written (counters glitch), stay in RUN and continue counting in the next frame's window.

Test Plan:
- Reset then idle: hold rst_n=0 3 cycles, release, sweep one frame with no start -> bram_we never 1; wr_add=0; busy=0; done=0.
- Full frame:
  - Stimulus: start pulse, then two full 800x600 VGA sweeps with pix_r/g/b = low 12 bits of wr_add from the previous cycle.
  - Expected: exactly 120000 writes; bram_addr 0..119999 ascending; bram_din matches bram_addr[11:0] on every write.
  - Expected: first write one cycle after (h_loc=201, v_loc=151); last write one cycle after (h_loc=600, v_loc=450).
  - Expected: done pulses once, 2 cycles after the last in-window cycle; busy drops with done.
- Mid-frame start: assert start at h_loc=300, v_loc=200 -> no writes until the next h_loc=0, v_loc=0; then a complete 120000-write frame.
- Abort: abort at wr_add=5000 -> bram_we=0 from the next edge; state IDLE; no done pulse; a later start yields a full frame from address 0.
- Boundary: check h_loc=200/601 and v_loc=150/451 -> no write produced; h_loc=201/600 on v_loc=151/450 -> write produced.
- Async reset mid-RUN: drop rst_n between clock edges at wr_add=60000 -> outputs at reset values before the next clk_40 edge; start ignored while rst_n=0.
